// File: rtl/residual_argmin.sv
// residual_argmin: per-offset SAD accumulator over a frame of residual beats.
// After the last beat, a row-major scan reports the minimum sum, then self-clears.
module residual_argmin #(
  parameter int POI_DEPTH = 4,
  parameter int POI_WIDTH = 4,
  parameter int ACC_W     = 8 + POI_DEPTH + POI_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [4:0]                     w_row,
  input  logic [POI_DEPTH+POI_WIDTH-1:0] POI_addr,
  input  logic [31:0][7:0]               residuals,
  output logic                           ready,
  output logic                           result_valid,
  output logic [4:0]                     best_row,
  output logic [4:0]                     best_col,
  output logic [ACC_W-1:0]               best_sad,
  output logic                           drop_err
);

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    SCAN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_W-1:0] acc [32][32];

  logic [4:0]       clr_row;
  logic [9:0]       idx;
  logic [ACC_W-1:0] cand_sad;
  logic [9:0]       cand_idx;
  logic [ACC_W-1:0] cur_sad;
  logic [ACC_W-1:0] win_sad;
  logic [9:0]       win_idx;
  logic             accept;
  logic             take;
  logic             scan_end;
  logic             unused_poi;

  assign unused_poi = ^POI_addr;

  assign ready        = (state == ACCUM);
  assign result_valid = (state == DONE);
  assign accept       = ready && en && in_valid;
  assign scan_end     = (state == SCAN) && (idx == 10'd1023);

  // Index 0 seeds the candidate; strict < keeps the lowest index on ties.
  assign cur_sad = acc[idx[9:5]][idx[4:0]];
  assign take    = (idx == 10'd0) || (cur_sad < cand_sad);
  assign win_sad = take ? cur_sad : cand_sad;
  assign win_idx = take ? idx : cand_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (clr_row == 5'd31) state_nxt = ACCUM;
      ACCUM: if (accept && in_last) state_nxt = SCAN;
      SCAN:  if (idx == 10'd1023) state_nxt = DONE;
      DONE:  state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_row  <= '0;
      idx      <= '0;
      cand_sad <= '0;
      cand_idx <= '0;
      best_row <= '0;
      best_col <= '0;
      best_sad <= '0;
      drop_err <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        clr_row <= clr_row + 5'd1;
      end
      if (state == SCAN) begin
        idx      <= idx + 10'd1;
        cand_sad <= win_sad;
        cand_idx <= win_idx;
      end
      if (scan_end) begin
        best_row <= win_idx[9:5];
        best_col <= win_idx[4:0];
        best_sad <= win_sad;
      end
      if (en && in_valid && !ready) begin
        drop_err <= 1'b1;
      end
    end
  end

  // Whole-row read-modify-write so back-to-back beats to one row chain correctly.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      for (int k = 0; k < 32; k++) begin
        acc[clr_row][k] <= '0;
      end
    end else if (accept && !reset) begin
      for (int k = 0; k < 32; k++) begin
        acc[w_row][k] <= acc[w_row][k] + ACC_W'(residuals[k]);
      end
    end
  end

endmodule
